// File: rtl/damage_arbiter.sv
// damage_arbiter: edge-detects per-source hit requests, grants them round-robin,
// applies one saturating damage subtraction per grant and then holds an
// invulnerability cooldown measured in frame ticks. KO latches at zero health.
module damage_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int HEALTH_W    = 8,
  parameter int DMG_W       = 8,
  parameter int HEALTH_INIT = 240,
  parameter int COOLDOWN    = 30
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     new_round,
  input  logic                     frame_tick,
  input  logic [NUM_SRC-1:0]       hit_req,
  input  logic [NUM_SRC*DMG_W-1:0] hit_dmg,
  output logic [NUM_SRC-1:0]       hit_ack,
  output logic                     hit_pulse,
  output logic [HEALTH_W-1:0]      health,
  output logic                     invuln,
  output logic                     ko
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(COOLDOWN + 2);
  localparam int CMP_W = (HEALTH_W > DMG_W) ? HEALTH_W : DMG_W;
  localparam logic [NUM_SRC-1:0] ONE_HOT0 = {{(NUM_SRC-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_COOL, S_KO} state_e;

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [NUM_SRC-1:0]   req_prev_q;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     idx_q, idx_d;
  logic [DMG_W-1:0]     dmg_q, dmg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [HEALTH_W-1:0]  health_q, health_d;
  logic [NUM_SRC-1:0]   ack_q, ack_d;
  logic                 pulse_q, pulse_d;
  logic                 invuln_q, invuln_d;
  logic                 ko_q, ko_d;

  logic [NUM_SRC-1:0]   rise_s;
  logic                 grant_found_s;
  logic [PTR_W-1:0]     grant_idx_s;
  logic [DMG_W-1:0]     grant_dmg_s;
  logic [PTR_W:0]       cand_s;
  logic [CMP_W-1:0]     health_ext_s, dmg_ext_s;
  logic [HEALTH_W-1:0]  new_health_s;

  assign rise_s = hit_req & ~req_prev_q;

  // Round-robin search of pending bits starting at rr_ptr, plus damage select.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    grant_dmg_s   = '0;
    cand_s        = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand_s = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (cand_s >= (PTR_W+1)'(NUM_SRC)) begin
        cand_s = cand_s - (PTR_W+1)'(NUM_SRC);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && pending_q[cand_s[PTR_W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[PTR_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_idx_s == PTR_W'(i)) begin
        grant_dmg_s = hit_dmg[i*DMG_W +: DMG_W];
      end else begin
        grant_dmg_s = grant_dmg_s;
      end
    end
  end

  // Saturating subtraction; damage wider than health compares zero-extended.
  always_comb begin
    health_ext_s = CMP_W'(health_q);
    dmg_ext_s    = CMP_W'(dmg_q);
    if (health_ext_s > dmg_ext_s) begin
      new_health_s = HEALTH_W'(health_ext_s - dmg_ext_s);
    end else begin
      new_health_s = '0;
    end
  end

  // Next-state, pending bookkeeping and registered-output decode.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | rise_s;
    rr_ptr_d  = rr_ptr_q;
    idx_d     = idx_q;
    dmg_d     = dmg_q;
    cnt_d     = cnt_q;
    health_d  = health_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found_s) begin
          // A fresh rise on the granted source in the same cycle survives.
          pending_d = (pending_q & ~(ONE_HOT0 << grant_idx_s)) | rise_s;
          idx_d     = grant_idx_s;
          dmg_d     = grant_dmg_s;
          if (grant_idx_s == PTR_W'(NUM_SRC - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = grant_idx_s + PTR_W'(1);
          end
          state_d = S_APPLY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_APPLY: begin
        health_d = new_health_s;
        if (new_health_s == '0) begin
          state_d = S_KO;
        end else if (COOLDOWN == 0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_COOL;
          cnt_d   = CNT_W'(COOLDOWN);
        end
      end
      S_COOL: begin
        // Hits landing during invulnerability are discarded, not deferred.
        pending_d = '0;
        if (frame_tick) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_KO: begin
        pending_d = '0;
        state_d   = S_KO;
      end
      default: begin
        state_d   = S_IDLE;
        pending_d = '0;
      end
    endcase
    if (new_round) begin
      health_d  = HEALTH_W'(HEALTH_INIT);
      state_d   = S_IDLE;
      pending_d = '0;
      rr_ptr_d  = '0;
      cnt_d     = '0;
    end else begin
      health_d = health_d;
    end
    pulse_d  = (state_d == S_APPLY);
    ack_d    = (state_d == S_APPLY) ? (ONE_HOT0 << idx_d) : '0;
    invuln_d = (state_d == S_COOL);
    ko_d     = (state_d == S_KO);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      req_prev_q <= '0;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
      dmg_q      <= '0;
      cnt_q      <= '0;
      health_q   <= HEALTH_W'(HEALTH_INIT);
      ack_q      <= '0;
      pulse_q    <= 1'b0;
      invuln_q   <= 1'b0;
      ko_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      req_prev_q <= hit_req;
      rr_ptr_q   <= rr_ptr_d;
      idx_q      <= idx_d;
      dmg_q      <= dmg_d;
      cnt_q      <= cnt_d;
      health_q   <= health_d;
      ack_q      <= ack_d;
      pulse_q    <= pulse_d;
      invuln_q   <= invuln_d;
      ko_q       <= ko_d;
    end
  end

  assign hit_ack   = ack_q;
  assign hit_pulse = pulse_q;
  assign health    = health_q;
  assign invuln    = invuln_q;
  assign ko        = ko_q;

endmodule

// File: tb/tb_damage_arbiter.sv
// Bench for damage_arbiter: one instance with a 30-frame cooldown, one with none,
// sharing all inputs. Expected hit order and health come from a small model.
module tb_damage_arbiter;

  localparam int N = 4;
  localparam int DW = 8;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          new_round = 1'b0;
  logic          frame_tick = 1'b0;
  logic [N-1:0]  hit_req = '0;
  logic [N*DW-1:0] hit_dmg = '0;

  logic [N-1:0]  hit_ack_cd, hit_ack_nc;
  logic          hit_pulse_cd, hit_pulse_nc;
  logic [7:0]    health_cd, health_nc;
  logic          invuln_cd, invuln_nc;
  logic          ko_cd, ko_nc;

  int chk_cnt = 0;
  int err_cnt = 0;

  logic [4:0] nc_log[$];
  logic [4:0] cd_log[$];

  always #5 Clk = ~Clk;

  damage_arbiter #(.NUM_SRC(N), .HEALTH_W(8), .DMG_W(DW), .HEALTH_INIT(240), .COOLDOWN(30)) dut_cd (
    .Clk(Clk), .Reset_n(Reset_n), .new_round(new_round), .frame_tick(frame_tick),
    .hit_req(hit_req), .hit_dmg(hit_dmg), .hit_ack(hit_ack_cd), .hit_pulse(hit_pulse_cd),
    .health(health_cd), .invuln(invuln_cd), .ko(ko_cd));

  damage_arbiter #(.NUM_SRC(N), .HEALTH_W(8), .DMG_W(DW), .HEALTH_INIT(240), .COOLDOWN(0)) dut_nc (
    .Clk(Clk), .Reset_n(Reset_n), .new_round(new_round), .frame_tick(frame_tick),
    .hit_req(hit_req), .hit_dmg(hit_dmg), .hit_ack(hit_ack_nc), .hit_pulse(hit_pulse_nc),
    .health(health_nc), .invuln(invuln_nc), .ko(ko_nc));

  // Record every cycle in which either DUT shows an ack or a pulse.
  always @(negedge Clk) begin
    if (Reset_n && (hit_pulse_nc || hit_ack_nc != 4'b0000)) nc_log.push_back({hit_pulse_nc, hit_ack_nc});
    if (Reset_n && (hit_pulse_cd || hit_ack_cd != 4'b0000)) cd_log.push_back({hit_pulse_cd, hit_ack_cd});
  end

  function automatic int sat_sub(int h, int d);
    return (h > d) ? h - d : 0;
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0; hit_req = '0; new_round = 1'b0; frame_tick = 1'b0; hit_dmg = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    nc_log.delete();
    cd_log.delete();
  endtask

  task automatic test_reset();
    do_reset();
    if (health_cd !== 8'd240 || health_nc !== 8'd240) begin
      err_cnt++; $display("FAIL reset_health: got %0d/%0d want 240", health_cd, health_nc);
    end
    chk_cnt++;
    if ({hit_ack_cd, hit_ack_nc, hit_pulse_cd, hit_pulse_nc, invuln_cd, invuln_nc, ko_cd, ko_nc} !== 14'd0) begin
      err_cnt++; $display("FAIL reset_flags: got nonzero ack/pulse/invuln/ko, want all 0");
    end
    chk_cnt++;
  endtask

  task automatic test_single_hit();
    int d;
    do_reset();
    d = $urandom_range(1, 100);
    hit_dmg = DW'(d);
    hit_req = 4'b0001;
    @(posedge Clk); @(negedge Clk);
    if (hit_ack_cd !== 4'b0000 || hit_pulse_cd !== 1'b0) begin
      err_cnt++; $display("FAIL single_early_ack: got ack=%b pulse=%b want 0", hit_ack_cd, hit_pulse_cd);
    end
    chk_cnt++;
    @(posedge Clk); @(negedge Clk);
    if (hit_ack_cd !== 4'b0001 || hit_pulse_cd !== 1'b1 || health_cd !== 8'd240) begin
      err_cnt++; $display("FAIL single_apply: got ack=%b pulse=%b health=%0d want 0001/1/240",
                          hit_ack_cd, hit_pulse_cd, health_cd);
    end
    chk_cnt++;
    @(posedge Clk); @(negedge Clk);
    if (health_cd !== 8'(240 - d) || invuln_cd !== 1'b1 || hit_ack_cd !== 4'b0000) begin
      err_cnt++; $display("FAIL single_after: got health=%0d invuln=%b ack=%b want %0d/1/0000",
                          health_cd, invuln_cd, hit_ack_cd, 240 - d);
    end
    chk_cnt++;
    if (health_nc !== 8'(240 - d) || invuln_nc !== 1'b0) begin
      err_cnt++; $display("FAIL single_nc: got health=%0d invuln=%b want %0d/0", health_nc, invuln_nc, 240 - d);
    end
    chk_cnt++;
    hit_req = 4'b0000;
    for (int k = 1; k <= 30; k++) begin
      step(1); frame_tick = 1'b1;
      step(1); frame_tick = 1'b0;
      @(negedge Clk);
      if (k == 29) begin
        if (invuln_cd !== 1'b1) begin
          err_cnt++; $display("FAIL cooldown_hold: got invuln=%b after 29 ticks want 1", invuln_cd);
        end
        chk_cnt++;
      end
      if (k == 30) begin
        if (invuln_cd !== 1'b0) begin
          err_cnt++; $display("FAIL cooldown_end: got invuln=%b after 30 ticks want 0", invuln_cd);
        end
        chk_cnt++;
      end
    end
  endtask

  task automatic test_round_robin();
    int h, ptr, cnt, s;
    logic [3:0] mask;
    logic [3:0] one;
    int dm[N];
    logic [4:0] exp_q[$];
    do_reset();
    h = 240; ptr = 0; one = 4'b0001;
    for (int r = 0; r < 6; r++) begin
      mask = (r == 0) ? 4'b0110 : 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        dm[i] = $urandom_range(0, 5);
        hit_dmg[i*DW +: DW] = DW'(dm[i]);
      end
      exp_q.delete();
      cnt = 0;
      for (int k = 0; k < N; k++) begin
        s = (ptr + k) % N;
        if (mask[s]) begin
          exp_q.push_back({1'b1, one << s});
          h = sat_sub(h, dm[s]);
          cnt++;
        end
      end
      for (int k = N - 1; k >= 0; k--) begin
        s = (ptr + k) % N;
        if (mask[s]) begin
          ptr = (s + 1) % N;
          break;
        end
      end
      nc_log.delete();
      step(1); hit_req = mask;
      step(2 * cnt + 4);
      hit_req = 4'b0000;
      step(2);
      if (nc_log.size() != exp_q.size()) begin
        err_cnt++; $display("FAIL rr_count: round %0d mask=%b got %0d acks want %0d", r, mask, nc_log.size(), exp_q.size());
      end else begin
        for (int j = 0; j < exp_q.size(); j++) begin
          if (nc_log[j] !== exp_q[j]) begin
            err_cnt++; $display("FAIL rr_order: round %0d slot %0d got %b want %b", r, j, nc_log[j], exp_q[j]);
          end
          chk_cnt++;
        end
      end
      chk_cnt++;
      if (health_nc !== 8'(h)) begin
        err_cnt++; $display("FAIL rr_health: round %0d got %0d want %0d", r, health_nc, h);
      end
      chk_cnt++;
    end
  endtask

  task automatic test_hold_toggle();
    int d;
    do_reset();
    d = $urandom_range(1, 50);
    hit_dmg = DW'(d);
    step(1); hit_req = 4'b0001;
    step(200);
    if (nc_log.size() != 1) begin
      err_cnt++; $display("FAIL hold_once: got %0d acks want 1", nc_log.size());
    end
    chk_cnt++;
    hit_req = 4'b0000;
    step(2);
    nc_log.delete();
    for (int t = 0; t < 3; t++) begin
      hit_req = 4'b0001; step(4);
      hit_req = 4'b0000; step(2);
    end
    if (nc_log.size() != 3) begin
      err_cnt++; $display("FAIL toggle_acks: got %0d acks want 3", nc_log.size());
    end
    chk_cnt++;
    if (health_nc !== 8'(sat_sub(240, 4 * d))) begin
      err_cnt++; $display("FAIL toggle_health: got %0d want %0d", health_nc, sat_sub(240, 4 * d));
    end
    chk_cnt++;
  endtask

  task automatic test_ko();
    int d2;
    do_reset();
    hit_dmg = DW'(225);
    step(1); hit_req = 4'b0001; step(4); hit_req = 4'b0000; step(2);
    if (health_nc !== 8'd15) begin
      err_cnt++; $display("FAIL ko_setup: got health=%0d want 15", health_nc);
    end
    chk_cnt++;
    d2 = $urandom_range(16, 255);
    hit_dmg = DW'(d2);
    hit_req = 4'b0001; step(4); hit_req = 4'b0000; step(1);
    if (health_nc !== 8'd0 || ko_nc !== 1'b1) begin
      err_cnt++; $display("FAIL ko_sat: dmg=%0d got health=%0d ko=%b want 0/1", d2, health_nc, ko_nc);
    end
    chk_cnt++;
    nc_log.delete();
    hit_dmg = {DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)), DW'(1), DW'(1)};
    hit_req = 4'b0110; step(10); hit_req = 4'b0000; step(1);
    if (nc_log.size() != 0 || health_nc !== 8'd0 || ko_nc !== 1'b1) begin
      err_cnt++; $display("FAIL ko_hold: got %0d acks health=%0d ko=%b want 0/0/1", nc_log.size(), health_nc, ko_nc);
    end
    chk_cnt++;
    new_round = 1'b1; step(1); new_round = 1'b0;
    @(negedge Clk);
    if (health_nc !== 8'd240 || ko_nc !== 1'b0) begin
      err_cnt++; $display("FAIL ko_new_round: got health=%0d ko=%b want 240/0", health_nc, ko_nc);
    end
    chk_cnt++;
  endtask

  task automatic test_cooldown_discard();
    int d;
    do_reset();
    d = $urandom_range(1, 100);
    hit_dmg = DW'(d);
    step(1); hit_req = 4'b0001;
    step(3); hit_req = 4'b0000;
    cd_log.delete();
    hit_dmg = {DW'(0), DW'($urandom_range(1, 100)), DW'(0), DW'(0)};
    for (int k = 1; k <= 30; k++) begin
      step(1); frame_tick = 1'b1;
      step(1); frame_tick = 1'b0;
      if (k == 10) hit_req = 4'b0100;
    end
    step(12);
    if (cd_log.size() != 0) begin
      err_cnt++; $display("FAIL cool_discard: got %0d acks want 0", cd_log.size());
    end
    chk_cnt++;
    if (health_cd !== 8'(240 - d) || invuln_cd !== 1'b0) begin
      err_cnt++; $display("FAIL cool_health: got health=%0d invuln=%b want %0d/0", health_cd, invuln_cd, 240 - d);
    end
    chk_cnt++;
    hit_req = 4'b0000;
  endtask

  task automatic test_async_reset_and_round();
    do_reset();
    hit_dmg = {DW'(0), DW'(0), DW'($urandom_range(1, 100)), DW'(0)};
    step(1); hit_req = 4'b0010;
    @(posedge Clk); @(posedge Clk); #2;
    if (hit_ack_cd !== 4'b0010) begin
      err_cnt++; $display("FAIL apply_before_reset: got ack=%b want 0010", hit_ack_cd);
    end
    chk_cnt++;
    Reset_n = 1'b0;
    #1;
    if (health_cd !== 8'd240 || hit_ack_cd !== 4'b0000 || hit_pulse_cd !== 1'b0) begin
      err_cnt++; $display("FAIL async_reset: got health=%0d ack=%b pulse=%b want 240/0000/0",
                          health_cd, hit_ack_cd, hit_pulse_cd);
    end
    chk_cnt++;
    hit_req = 4'b0000;
    @(negedge Clk);
    Reset_n = 1'b1;
    step(2);
    nc_log.delete(); cd_log.delete();
    new_round = 1'b1; hit_req = 4'b0001; hit_dmg = DW'(50);
    step(1); new_round = 1'b0;
    step(20);
    if (nc_log.size() != 0 || cd_log.size() != 0 || health_nc !== 8'd240 || health_cd !== 8'd240) begin
      err_cnt++; $display("FAIL round_held_req: got acks=%0d/%0d health=%0d/%0d want 0/0/240/240",
                          nc_log.size(), cd_log.size(), health_nc, health_cd);
    end
    chk_cnt++;
    hit_req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_round_robin();
    test_hold_toggle();
    test_ko();
    test_cooldown_discard();
    test_async_reset_and_round();
    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
